// File: rtl/i2c_eeprom_slave.sv
// -----------------------------------------------------------------------------
// i2c_eeprom_slave
// I2C responder that behaves like a 24AA02-class serial EEPROM: a 256 x 8 byte
// array with 8-byte write pages, 7-bit addressing, standard/fast mode and no
// clock stretching. It lets an on-chip I2C master exercise EEPROM traffic
// without an external part.
//
// Ports
//   clk        system clock (50 MHz)
//   rst_n      asynchronous active-low reset
//   i2c_scl    bus clock input (externally pulled up)
//   i2c_sda    open-drain data: driven to 0 or released ('z')
//   wr_strobe  one-clk pulse per byte committed to the array
//   wr_addr    array address of the last commit
//   wr_data    data of the last commit
//   busy       high from an addressed START until the matching STOP
//
// The array contents are not reset.
// -----------------------------------------------------------------------------
module i2c_eeprom_slave #(
  parameter logic [6:0] DEV_ADDR  = 7'b1010000,
  parameter int         PAGE_BITS = 3,
  parameter int         FILT_LEN  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV_ADDR, S_IGNORE, S_ACK_DEV, S_WORD_ADDR,
    S_ACK_WORD, S_WR_DATA, S_ACK_WR, S_RD_DATA, S_RD_MACK
  } state_e;

  // Input conditioning: 2-FF synchronizer followed by a stable filter.
  // The filtered level only changes when the last FILT_LEN synchronized
  // samples (including the current one) agree.
  logic [1:0]          scl_sync_q, sda_sync_q;
  logic [FILT_LEN-2:0] scl_hist_q, sda_hist_q;
  logic [FILT_LEN-1:0] scl_win, sda_win;
  logic                scl_q, scl_d, sda_q, sda_d;

  assign scl_win = {scl_hist_q, scl_sync_q[1]};
  assign sda_win = {sda_hist_q, sda_sync_q[1]};

  always_comb begin
    scl_d = scl_q;
    if (&scl_win)       scl_d = 1'b1;
    else if (~|scl_win) scl_d = 1'b0;
    sda_d = sda_q;
    if (&sda_win)       sda_d = 1'b1;
    else if (~|sda_win) sda_d = 1'b0;
  end

  // Events are taken from the next filtered value so that the FSM reacts on
  // the same edge the filter accepts the new level.
  logic scl_rise, scl_fall, start_c, stop_c, bit_in;
  assign scl_rise = scl_d & ~scl_q;
  assign scl_fall = ~scl_d & scl_q;
  assign start_c  = scl_q & scl_d & sda_q & ~sda_d;
  assign stop_c   = scl_q & scl_d & ~sda_q & sda_d;
  assign bit_in   = sda_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], i2c_scl};
      sda_sync_q <= {sda_sync_q[0], i2c_sda};
      scl_hist_q <= scl_win[FILT_LEN-2:0];
      sda_hist_q <= sda_win[FILT_LEN-2:0];
      scl_q      <= scl_d;
      sda_q      <= sda_d;
    end
  end

  // Protocol FSM and datapath
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        sda_low_q, sda_low_d;
  logic        rw_q, rw_d;
  logic        busy_q, busy_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  rd_byte;
  logic [7:0]  mem_q [256];

  assign rd_byte = mem_q[ptr_q];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    ptr_d       = ptr_q;
    sda_low_d   = sda_low_q;
    rw_d        = rw_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_we      = 1'b0;
    mem_wdata   = {shreg_q[6:0], bit_in};

    if (start_c) begin
      // Repeated START keeps ptr so a random read can follow a dummy write.
      state_d   = S_DEV_ADDR;
      cnt_d     = 4'd0;
      sda_low_d = 1'b0;
    end else if (stop_c) begin
      state_d   = S_IDLE;
      cnt_d     = 4'd0;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_IGNORE: sda_low_d = 1'b0;

        S_DEV_ADDR: begin
          if (scl_rise && cnt_q != 4'd8) begin
            shreg_d = {shreg_q[6:0], bit_in};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = 4'd0;
            if (shreg_q[7:1] == DEV_ADDR) begin
              state_d   = S_ACK_DEV;
              sda_low_d = 1'b1;
              busy_d    = 1'b1;
              rw_d      = shreg_q[0];
            end else begin
              state_d = S_IGNORE;
            end
          end
        end

        S_ACK_DEV: begin
          if (scl_fall) begin
            cnt_d = 4'd0;
            if (rw_q) begin
              state_d   = S_RD_DATA;
              shreg_d   = rd_byte;
              sda_low_d = ~rd_byte[7];
            end else begin
              state_d   = S_WORD_ADDR;
              sda_low_d = 1'b0;
            end
          end
        end

        S_WORD_ADDR: begin
          if (scl_rise && cnt_q != 4'd8) begin
            shreg_d = {shreg_q[6:0], bit_in};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            ptr_d     = shreg_q;
            cnt_d     = 4'd0;
            state_d   = S_ACK_WORD;
            sda_low_d = 1'b1;
          end
        end

        S_ACK_WORD: begin
          if (scl_fall) begin
            state_d   = S_WR_DATA;
            sda_low_d = 1'b0;
            cnt_d     = 4'd0;
          end
        end

        S_WR_DATA: begin
          if (scl_rise && cnt_q != 4'd8) begin
            shreg_d = {shreg_q[6:0], bit_in};
            cnt_d   = cnt_q + 4'd1;
            // Commit only on the 8th bit, so an aborted byte never lands.
            if (cnt_q == 4'd7) begin
              mem_we      = 1'b1;
              wr_strobe_d = 1'b1;
              wr_addr_d   = ptr_q;
              wr_data_d   = mem_wdata;
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d     = 4'd0;
            state_d   = S_ACK_WR;
            sda_low_d = 1'b1;
          end
        end

        S_ACK_WR: begin
          if (scl_fall) begin
            // Page wrap: only the in-page bits advance.
            ptr_d     = {ptr_q[7:PAGE_BITS], ptr_q[PAGE_BITS-1:0] + PAGE_BITS'(1)};
            state_d   = S_WR_DATA;
            sda_low_d = 1'b0;
            cnt_d     = 4'd0;
          end
        end

        S_RD_DATA: begin
          if (scl_rise && cnt_q != 4'd8) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d   = S_RD_MACK;
              sda_low_d = 1'b0;
              cnt_d     = 4'd0;
            end else begin
              shreg_d   = {shreg_q[6:0], 1'b0};
              sda_low_d = ~shreg_q[6];
            end
          end
        end

        S_RD_MACK: begin
          if (scl_rise && cnt_q == 4'd0) begin
            ptr_d = ptr_q + 8'd1;
            if (bit_in) state_d = S_IGNORE;
            else        cnt_d   = 4'd1;
          end else if (scl_fall && cnt_q == 4'd1) begin
            // Read load happens on a fall; writes only on rises, so the
            // single-port array never sees both in one clk.
            state_d   = S_RD_DATA;
            shreg_d   = rd_byte;
            sda_low_d = ~rd_byte[7];
            cnt_d     = 4'd0;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      shreg_q     <= 8'd0;
      ptr_q       <= 8'd0;
      sda_low_q   <= 1'b0;
      rw_q        <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 8'd0;
      wr_data_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      ptr_q       <= ptr_d;
      sda_low_q   <= sda_low_d;
      rw_q        <= rw_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[ptr_q] <= mem_wdata;
  end

  // Reset clears sda_low_q asynchronously, releasing the bus at once.
  assign i2c_sda   = sda_low_q ? 1'b0 : 1'bz;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
`timescale 1ns/1ps
module tb_i2c_eeprom_slave;

  localparam int FILT_LEN = 3;
  localparam int Q        = 200;  // quarter SCL period, 10 clks

  logic       clk;
  logic       rst_n;
  logic       scl;
  logic       m_low;
  wire        sda;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_eeprom_slave #(
    .DEV_ADDR (7'b1010000),
    .PAGE_BITS(3),
    .FILT_LEN (FILT_LEN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i2c_scl  (scl),
    .i2c_sda  (sda),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int          n_checks = 0;
  int          n_errs   = 0;
  int          unexp_wr = 0;
  int          slave_low_cnt = 0;
  logic        busy_seen = 1'b0;
  longint      t_stop = 0;
  longint      t_busy_fall = 0;
  int          glitch_at = -1;
  logic [7:0]  model [256];
  logic [15:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  logic [7:0]  wq [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard side for commits: pop the expected (addr,data) per strobe.
  always @(negedge clk) begin
    if (wr_strobe) begin
      if (exp_wr.size() > 0) begin
        logic [15:0] e;
        e = exp_wr.pop_front();
        chk("wr_commit", {16'h0, wr_addr, wr_data}, {16'h0, e});
      end else begin
        unexp_wr++;
      end
    end
    if (!m_low && sda == 1'b0) slave_low_cnt++;
    if (busy) busy_seen = 1'b1;
  end

  always @(negedge busy) t_busy_fall = $time;

  task automatic send_bit(input logic b);
    m_low = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic get_bit(output logic b);
    m_low = 1'b0; #Q; scl = 1'b1; #Q; b = sda; #Q; scl = 1'b0; #Q;
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      if (i == glitch_at) begin
        // One-clk SCL pulse while SCL is low; the filter must swallow it.
        m_low = ~d[i]; #(Q/5); scl = 1'b1; #20; scl = 1'b0; #(Q - Q/5 - 20);
        scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
      end else begin
        send_bit(d[i]);
      end
    end
    get_bit(ack);
  endtask

  task automatic get_byte(output logic [7:0] d, input logic nack);
    for (int i = 7; i >= 0; i--) get_bit(d[i]);
    send_bit(nack);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; #Q; scl = 1'b1; #Q; m_low = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; t_stop = $time; #(2*Q);
  endtask

  // Write wq[] starting at addr; expected commits follow the page-wrap rule.
  task automatic do_write(input logic [7:0] addr);
    logic ack;
    logic [7:0] a;
    i2c_start();
    put_byte(8'hA0, ack); chk("wr_ack_dev", ack, 0);
    put_byte(addr, ack);  chk("wr_ack_word", ack, 0);
    for (int i = 0; i < wq.size(); i++) begin
      a = {addr[7:3], 3'(addr[2:0] + i[2:0])};
      model[a] = wq[i];
      exp_wr.push_back({a, wq[i]});
      put_byte(wq[i], ack); chk("wr_ack_data", ack, 0);
    end
    wq.delete();
  endtask

  task automatic do_read(input logic [7:0] addr, input int n);
    logic ack;
    logic [7:0] d;
    logic [7:0] e;
    i2c_start();
    put_byte(8'hA0, ack); chk("rd_ack_dev", ack, 0);
    put_byte(addr, ack);  chk("rd_ack_word", ack, 0);
    i2c_start();
    put_byte(8'hA1, ack); chk("rd_ack_devr", ack, 0);
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(model[8'(addr + i)]);
      get_byte(d, (i == n - 1));
      e = exp_rd.pop_front();
      chk("rd_data", d, e);
    end
    chk("rd_release", sda, 1);
    i2c_stop();
  endtask

  initial begin
    logic ack;
    rst_n = 1'b0; scl = 1'b1; m_low = 1'b0;
    repeat (3) @(posedge clk);
    #5;
    chk("rst_busy", busy, 0);
    chk("rst_strobe", wr_strobe, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_sda", sda, 1);
    rst_n = 1'b1;
    #(2*Q);

    // Byte write with busy latency after STOP
    wq.push_back(8'h5A);
    do_write(8'h12);
    chk("busy_during", busy, 1);
    t_busy_fall = 0;
    i2c_stop();
    chk("busy_lat", 32'(t_busy_fall - t_stop), 15 + 20 * (FILT_LEN + 1));

    // Random read
    do_read(8'h12, 1);

    // Page wrap
    wq.push_back(8'h55);
    do_write(8'h08); i2c_stop();
    wq.push_back(8'h01); wq.push_back(8'h02); wq.push_back(8'h03); wq.push_back(8'h04);
    do_write(8'h06); i2c_stop();
    do_read(8'h06, 3);
    do_read(8'h00, 2);

    // Glitch on SCL during a data byte
    glitch_at = 3;
    wq.push_back(8'h77);
    do_write(8'h40);
    glitch_at = -1;
    i2c_stop();
    do_read(8'h40, 1);

    // Wrong device address
    slave_low_cnt = 0; busy_seen = 1'b0;
    i2c_start();
    put_byte(8'hA2, ack); chk("bad_nack_dev", ack, 1);
    put_byte(8'h12, ack); chk("bad_nack_b1", ack, 1);
    put_byte(8'h99, ack); chk("bad_nack_b2", ack, 1);
    i2c_stop();
    chk("bad_sda_low", slave_low_cnt, 0);
    chk("bad_busy", busy_seen, 0);

    // STOP after 4 data bits: nothing committed
    i2c_start();
    put_byte(8'hA0, ack); chk("ab_ack_dev", ack, 0);
    put_byte(8'h50, ack); chk("ab_ack_word", ack, 0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    i2c_stop();
    chk("ab_wr_data", wr_data, 8'h77);

    // Reset while the slave drives read data (0x5A, MSB 0)
    i2c_start();
    put_byte(8'hA0, ack); chk("rr_ack_dev", ack, 0);
    put_byte(8'h12, ack); chk("rr_ack_word", ack, 0);
    i2c_start();
    put_byte(8'hA1, ack); chk("rr_ack_devr", ack, 0);
    chk("rr_drive_low", sda, 0);
    rst_n = 1'b0;
    #1;
    chk("rr_sda_rel", sda, 1);
    chk("rr_busy", busy, 0);
    #39;
    rst_n = 1'b1;
    #160;
    i2c_stop();
    chk("rr_wr_addr", wr_addr, 0);

    // Sequential read wrapping 0xFF -> 0x00
    wq.push_back(8'hAA); wq.push_back(8'hBB);
    do_write(8'hFE); i2c_stop();
    wq.push_back(8'hCC);
    do_write(8'h00); i2c_stop();
    do_read(8'hFE, 3);

    chk("wr_queue_left", exp_wr.size(), 0);
    chk("unexpected_wr", unexp_wr, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
